// File: rtl/gameboycolor.sv
// Serial game controller poller: latches and clocks the pad at ~60 Hz, shows buttons or poll count on LEDs.
// Define GBC_FAST_POLL_EN for the short simulation timing (TICK = 4, PERIOD = 256).
module gameboycolor #(
`ifdef GBC_FAST_POLL_EN
    parameter int unsigned TICK   = 32'd4,
    parameter int unsigned PERIOD = 32'd256
`else
    parameter int unsigned TICK   = 32'd198,
    parameter int unsigned PERIOD = 32'd550000
`endif
) (
    input  logic CLK_33MHZ_FPGA,
    input  logic GPIO_SW_W,
    output logic HDR2_2_SM_8_N,
    output logic HDR2_4_SM_8_P,
    input  logic HDR2_6_SM_7_N,
    input  logic GPIO_DIP_SW1,
    output logic GPIO_LED_0,
    output logic GPIO_LED_1,
    output logic GPIO_LED_2,
    output logic GPIO_LED_3,
    output logic GPIO_LED_4,
    output logic GPIO_LED_5,
    output logic GPIO_LED_6,
    output logic GPIO_LED_7
);

    localparam int unsigned TICK_W = (TICK > 32'd1) ? $clog2(TICK) : 1;
    localparam int unsigned PER_W  = (PERIOD > 32'd1) ? $clog2(PERIOD) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK - 32'd1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_READ0    = 3'd2,
        ST_PULSE_HI = 3'd3,
        ST_PULSE_LO = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    logic              clk;
    logic              rst_n;
    state_t            state_r;
    state_t            state_next_s;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [PER_W-1:0]  period_cnt_r;
    logic              tick_s;
    logic              period_end_s;
    logic              start_s;
    logic              sample_s;
    logic              commit_s;
    logic              latch_tick_r;
    logic              latch_tick_next_s;
    logic [2:0]        bit_idx_r;
    logic [2:0]        bit_idx_next_s;
    logic [1:0]        data_sync_r;
    logic [1:0]        dip_sync_r;
    logic [7:0]        shadow_r;
    logic [7:0]        buttons_r;
    logic [7:0]        poll_count_r;
    logic              latch_r;
    logic              pulse_r;
    logic [7:0]        led_r;

    assign clk   = CLK_33MHZ_FPGA;
    assign rst_n = GPIO_SW_W;

    assign tick_s       = (tick_cnt_r == TICK_LAST);
    assign period_end_s = (period_cnt_r == PER_LAST);

    // Tick divider; restarted at poll start so every state lasts whole ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (start_s || tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Free-running poll period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_r <= {PER_W{1'b0}};
        end else if (period_end_s) begin
            period_cnt_r <= {PER_W{1'b0}};
        end else begin
            period_cnt_r <= period_cnt_r + PER_W'(1);
        end
    end

    // Poll FSM state, sub-counters and registered controller strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            latch_tick_r <= 1'b0;
            bit_idx_r    <= 3'd0;
            latch_r      <= 1'b0;
            pulse_r      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            latch_tick_r <= latch_tick_next_s;
            bit_idx_r    <= bit_idx_next_s;
            latch_r      <= (state_next_s == ST_LATCH);
            pulse_r      <= (state_next_s == ST_PULSE_HI);
        end
    end

    // Next-state logic and per-cycle sample/commit strobes.
    always_comb begin
        state_next_s      = state_r;
        latch_tick_next_s = latch_tick_r;
        bit_idx_next_s    = bit_idx_r;
        start_s           = 1'b0;
        sample_s          = 1'b0;
        commit_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (period_end_s) begin
                    state_next_s      = ST_LATCH;
                    start_s           = 1'b1;
                    latch_tick_next_s = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (tick_s && latch_tick_r) begin
                    state_next_s = ST_READ0;
                end else if (tick_s) begin
                    latch_tick_next_s = 1'b1;
                end else begin
                    state_next_s = ST_LATCH;
                end
            end
            ST_READ0: begin
                if (tick_s) begin
                    state_next_s   = ST_PULSE_HI;
                    sample_s       = 1'b1;
                    bit_idx_next_s = 3'd1;
                end else begin
                    state_next_s = ST_READ0;
                end
            end
            ST_PULSE_HI: begin
                if (tick_s) begin
                    state_next_s = ST_PULSE_LO;
                end else begin
                    state_next_s = ST_PULSE_HI;
                end
            end
            ST_PULSE_LO: begin
                if (tick_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = ST_DONE;
                    sample_s     = 1'b1;
                end else if (tick_s) begin
                    state_next_s   = ST_PULSE_HI;
                    sample_s       = 1'b1;
                    bit_idx_next_s = bit_idx_r + 3'd1;
                end else begin
                    state_next_s = ST_PULSE_LO;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
                commit_s     = 1'b1;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Input synchronizers for the pad data line and the page switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync_r <= 2'b00;
            dip_sync_r  <= 2'b00;
        end else begin
            data_sync_r <= {data_sync_r[0], HDR2_6_SM_7_N};
            dip_sync_r  <= {dip_sync_r[0], GPIO_DIP_SW1};
        end
    end

    // Bits arrive A first, so shifting in from the top leaves A at bit 0 after eight samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= 8'h00;
        end else if (sample_s) begin
            shadow_r <= {~data_sync_r[1], shadow_r[7:1]};
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Visible button register and poll count only change together in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons_r    <= 8'h00;
            poll_count_r <= 8'h00;
        end else if (commit_s) begin
            buttons_r    <= shadow_r;
            poll_count_r <= poll_count_r + 8'd1;
        end else begin
            buttons_r    <= buttons_r;
            poll_count_r <= poll_count_r;
        end
    end

    // LED page register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 8'h00;
        end else begin
            led_r <= dip_sync_r[1] ? poll_count_r : buttons_r;
        end
    end

    assign HDR2_2_SM_8_N = latch_r;
    assign HDR2_4_SM_8_P = pulse_r;
    assign GPIO_LED_0    = led_r[0];
    assign GPIO_LED_1    = led_r[1];
    assign GPIO_LED_2    = led_r[2];
    assign GPIO_LED_3    = led_r[3];
    assign GPIO_LED_4    = led_r[4];
    assign GPIO_LED_5    = led_r[5];
    assign GPIO_LED_6    = led_r[6];
    assign GPIO_LED_7    = led_r[7];

endmodule

// File: tb/tb_gameboycolor.sv
// Scoreboard bench for gameboycolor with fast timing (TICK = 4, PERIOD = 256) and a serial pad model.
`timescale 1ns/1ps
module tb_gameboycolor;

    logic       clk;
    logic       rst_n;
    logic       latch;
    logic       pulse;
    logic       data;
    logic       dip;
    logic [7:0] led;
    logic       led0, led1, led2, led3, led4, led5, led6, led7;

    int         checks;
    int         failures;
    logic [7:0] exp_q[$];
    int         model_polls;
    int         polls_checked;
    int         polls_since_rst;
    int         byte_mode;      // 0 = random byte, 1 = fixed_byte
    logic [7:0] fixed_byte;
    int         dip_mode;       // 0, 1 = fixed, 2 = random per poll

    gameboycolor #(.TICK(32'd4), .PERIOD(32'd256)) dut (
        .CLK_33MHZ_FPGA(clk),
        .GPIO_SW_W     (rst_n),
        .HDR2_2_SM_8_N (latch),
        .HDR2_4_SM_8_P (pulse),
        .HDR2_6_SM_7_N (data),
        .GPIO_DIP_SW1  (dip),
        .GPIO_LED_0    (led0),
        .GPIO_LED_1    (led1),
        .GPIO_LED_2    (led2),
        .GPIO_LED_3    (led3),
        .GPIO_LED_4    (led4),
        .GPIO_LED_5    (led5),
        .GPIO_LED_6    (led6),
        .GPIO_LED_7    (led7)
    );

    assign led = {led7, led6, led5, led4, led3, led2, led1, led0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pad model: loads a byte on latch, presents ~bit0, shifts on each pulse rise; pushes the expected LEDs.
    initial begin
        logic       prev_l;
        logic       prev_p;
        int         bitpos;
        logic [7:0] cur_byte;
        data = 1'b0;
        dip = 1'b0;
        prev_l = 1'b0;
        prev_p = 1'b0;
        bitpos = 0;
        cur_byte = 8'h00;
        model_polls = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_polls = 0;
                prev_l = 1'b0;
                prev_p = 1'b0;
            end else begin
                if (latch && !prev_l) begin
                    cur_byte = (byte_mode == 0) ? 8'($urandom_range(0, 255)) : fixed_byte;
                    dip = (dip_mode == 2) ? 1'($urandom_range(0, 1)) : (dip_mode == 1);
                    bitpos = 0;
                    data = ~cur_byte[0];
                    model_polls = (model_polls + 1) % 256;
                    exp_q.push_back(dip ? 8'(model_polls) : cur_byte);
                end else if (pulse && !prev_p && bitpos < 7) begin
                    bitpos++;
                    data = ~cur_byte[bitpos];
                end
                prev_l = latch;
                prev_p = pulse;
            end
        end
    end

    // Monitor: measures latch/pulse shapes and compares LEDs shortly after each poll's last pulse.
    initial begin
        logic prev_l;
        logic prev_p;
        int   lw, pw, pcount, timer;
        prev_l = 1'b0;
        prev_p = 1'b0;
        lw = 0; pw = 0; pcount = 0; timer = 0;
        polls_checked = 0;
        polls_since_rst = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_l = 1'b0; prev_p = 1'b0;
                lw = 0; pw = 0; pcount = 0; timer = 0;
                polls_since_rst = 0;
            end else begin
                if (timer > 0) begin
                    timer--;
                    if (timer == 0) begin
                        check("pulse_count", pcount, 7);
                        if (exp_q.size() == 0) begin
                            check("scoreboard_has_entry", 0, 1);
                        end else begin
                            check("leds", led, exp_q.pop_front());
                        end
                        polls_checked++;
                    end
                end
                if (latch) lw++;
                if (latch && !prev_l) begin
                    pcount = 0;
                    polls_since_rst++;
                end
                if (!latch && prev_l) begin
                    check("latch_width", lw, 8);
                    lw = 0;
                end
                if (pulse) pw++;
                if (!pulse && prev_p) begin
                    check("pulse_width", pw, 4);
                    pw = 0;
                    pcount++;
                    if (pcount == 7) timer = 8;
                end
                if (pulse && latch) check("latch_pulse_overlap", 1, 0);
                prev_l = latch;
                prev_p = pulse;
            end
        end
    end

    task automatic release_and_time(input string name);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (latch !== 1'b1 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, 256);
    endtask

    task automatic wait_polls(input int n);
        int target;
        int budget;
        target = polls_checked + n;
        budget = 0;
        while (polls_checked < target && budget < n * 300 + 600) begin
            @(negedge clk);
            budget++;
        end
        check("poll_progress", (polls_checked >= target) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int n;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        byte_mode = 1;
        fixed_byte = 8'hFF;
        dip_mode = 0;

        repeat (10) begin
            @(negedge clk);
            check("rst_latch", latch, 0);
            check("rst_pulse", pulse, 0);
            check("rst_leds", led, 0);
        end

        release_and_time("first_poll_delay");
        wait_polls(2);
        check("all_pressed_leds", led, 8'hFF);

        fixed_byte = 8'h00;
        wait_polls(2);
        check("none_pressed_leds", led, 8'h00);

        fixed_byte = 8'h01;
        wait_polls(2);
        check("bit0_window_leds", led, 8'h01);

        do_reset();
        dip_mode = 1;
        release_and_time("count_poll_delay");
        wait_polls(3);
        check("count_after_3", led, 8'h03);
        wait_polls(253);
        check("count_wrap_256", led, 8'h00);

        dip_mode = 2;
        byte_mode = 0;
        wait_polls(12);

        dip_mode = 0;
        byte_mode = 1;
        fixed_byte = 8'hA5;
        do_reset();
        release_and_time("abort_setup_delay");
        n = 0;
        while (!(polls_since_rst == 2 && pulse === 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("second_poll_pulse_hi", pulse, 1);
        rst_n = 1'b0;
        #1;
        check("abort_pulse_drop", pulse, 0);
        check("abort_latch", latch, 0);
        check("abort_leds", led, 8'h00);
        repeat (3) @(negedge clk);
        check("abort_leds_held", led, 8'h00);
        release_and_time("post_abort_delay");
        wait_polls(1);
        check("post_abort_leds", led, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
